simpleuart_tx_arbiter: RTL and testbench

Controller that shares the simpleuart transmit data register between two byte-stream requesters (e.g. CPU-side AXI path and a boot/debug message source) and owns the divider register. Programs a default baud divider after reset, accepts runtime divider updates, and round-robins bytes into the UART while honouring the UART's `reg_dat_wait` back-pressure. Sits between the requesters and the simpleuart core's register port.

---
 rtl/simpleuart_tx_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_simpleuart_tx_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simpleuart_tx_arbiter.sv
// simpleuart_tx_arbiter
// Shares the simpleuart transmit data register between two byte requesters and
// owns the baud divider register. After reset the default divider is written
// once; later divider updates arrive on div_cfg_*. Bytes are round-robined into
// the UART and each write is held until the core drops reg_dat_wait.
//
// Optional feature: define UART_ARB_PKT_LOCK_EN to keep the grant on one
// requester until it sends a byte with *_last set (divider updates are held
// off while a packet is open). Without it *_last is ignored and locked is 0.
//
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   reqN_valid/data/last   requester N byte stream (N = 0, 1)
//   reqN_ready             combinational; byte taken on valid && ready
//   div_cfg_valid/data     divider update request
//   div_cfg_ready          combinational; update taken on valid && ready
//   reg_div_we/di          UART divider register write port
//   reg_dat_we/di          UART data register write port
//   reg_dat_wait           UART busy; data write completes when low
//   busy                   controller not idle
//   grant_id               requester of the last accepted byte
//   locked                 packet lock active
module simpleuart_tx_arbiter #(
    parameter logic [31:0] DEFAULT_DIV = 32'd104
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req0_valid,
    input  logic [7:0]  req0_data,
    input  logic        req0_last,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [7:0]  req1_data,
    input  logic        req1_last,
    output logic        req1_ready,
    input  logic        div_cfg_valid,
    input  logic [31:0] div_cfg_data,
    output logic        div_cfg_ready,
    output logic [3:0]  reg_div_we,
    output logic [31:0] reg_div_di,
    output logic        reg_dat_we,
    output logic [31:0] reg_dat_di,
    input  logic        reg_dat_wait,
    output logic        busy,
    output logic        grant_id,
    output logic        locked
);

    localparam int unsigned DW = 32;
    localparam int unsigned BW = 8;

    typedef enum logic [1:0] {INIT, IDLE, ISSUE, CFG} state_t;

    state_t          state, state_n;
    logic [3:0]      reg_div_we_n;
    logic [DW-1:0]   reg_div_di_n;
    logic            reg_dat_we_n;
    logic [DW-1:0]   reg_dat_di_n;
    logic            busy_n;
    logic            grant_id_n;
    logic            rr_last, rr_last_n;
    logic            locked_q;

    logic            win_id;
    logic            win_valid;
    logic [BW-1:0]   win_byte;
    logic            cfg_sel;
    logic            data_sel;

`ifdef UART_ARB_PKT_LOCK_EN
    logic            locked_n;
    logic            win_last;
    assign win_last = win_id ? req1_last : req0_last;
`else
    assign locked_q = 1'b0;
    logic unused_last;
    assign unused_last = &{1'b0, req0_last, req1_last};
`endif

    assign locked = locked_q;

    // Data source selection: locked owner only, else round-robin on ties.
    always_comb begin
        win_id    = 1'b0;
        win_valid = 1'b0;
        if (locked_q) begin
            win_id    = grant_id;
            win_valid = grant_id ? req1_valid : req0_valid;
        end else if (req0_valid && req1_valid) begin
            win_id    = ~rr_last;
            win_valid = 1'b1;
        end else begin
            win_id    = req1_valid;
            win_valid = req0_valid | req1_valid;
        end
    end

    assign win_byte      = win_id ? req1_data : req0_data;
    assign cfg_sel       = (state == IDLE) && div_cfg_valid && !locked_q;
    assign data_sel      = (state == IDLE) && !cfg_sel && win_valid;
    assign div_cfg_ready = cfg_sel;
    assign req0_ready    = data_sel && !win_id;
    assign req1_ready    = data_sel && win_id;

    // Next-state and registered-output logic.
    always_comb begin
        state_n      = state;
        reg_div_we_n = 4'h0;
        reg_div_di_n = reg_div_di;
        reg_dat_we_n = reg_dat_we;
        reg_dat_di_n = reg_dat_di;
        grant_id_n   = grant_id;
        rr_last_n    = rr_last;
`ifdef UART_ARB_PKT_LOCK_EN
        locked_n     = locked_q;
`endif
        case (state)
            INIT: begin
                reg_div_we_n = 4'hF;
                reg_div_di_n = DEFAULT_DIV;
                state_n      = IDLE;
            end
            IDLE: begin
                if (cfg_sel) begin
                    reg_div_we_n = 4'hF;
                    reg_div_di_n = div_cfg_data;
                    state_n      = CFG;
                end else if (data_sel) begin
                    reg_dat_we_n = 1'b1;
                    reg_dat_di_n = {(DW-BW)'(0), win_byte};
                    grant_id_n   = win_id;
                    rr_last_n    = win_id;
`ifdef UART_ARB_PKT_LOCK_EN
                    locked_n     = !win_last;
`endif
                    state_n      = ISSUE;
                end
            end
            ISSUE: begin
                // Write completes on the edge where the core is not busy.
                if (!reg_dat_wait) begin
                    reg_dat_we_n = 1'b0;
                    state_n      = IDLE;
                end
            end
            CFG: begin
                state_n = IDLE;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= INIT;
            reg_div_we <= 4'h0;
            reg_div_di <= '0;
            reg_dat_we <= 1'b0;
            reg_dat_di <= '0;
            busy       <= 1'b0;
            grant_id   <= 1'b0;
            rr_last    <= 1'b1;
`ifdef UART_ARB_PKT_LOCK_EN
            locked_q   <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            reg_div_we <= reg_div_we_n;
            reg_div_di <= reg_div_di_n;
            reg_dat_we <= reg_dat_we_n;
            reg_dat_di <= reg_dat_di_n;
            busy       <= busy_n;
            grant_id   <= grant_id_n;
            rr_last    <= rr_last_n;
`ifdef UART_ARB_PKT_LOCK_EN
            locked_q   <= locked_n;
`endif
        end
    end

endmodule

// File: tb/tb_simpleuart_tx_arbiter.sv
// Scoreboard bench for simpleuart_tx_arbiter: stimulus pushes expected bytes
// and divider writes into queues; a negedge monitor pops them as the UART port
// shows completed writes and checks arbitration against a request-level model.
module tb_simpleuart_tx_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req0_valid, req1_valid;
    logic [7:0]  req0_data, req1_data;
    logic        req0_last, req1_last;
    logic        req0_ready, req1_ready;
    logic        div_cfg_valid;
    logic [31:0] div_cfg_data;
    logic        div_cfg_ready;
    logic [3:0]  reg_div_we;
    logic [31:0] reg_div_di;
    logic        reg_dat_we;
    logic [31:0] reg_dat_di;
    logic        reg_dat_wait;
    logic        busy, grant_id, locked;

    int total = 0;
    int bad   = 0;

    logic [7:0]  exp_q0[$];
    logic [7:0]  exp_q1[$];
    logic [31:0] exp_div[$];
    logic [7:0]  wr_log[$];
    logic        gr_log[$];

    logic        acc0, acc1, accc;
    logic        mdl_last   = 1'b1;
    logic        mdl_owner  = 1'b0;
    logic        mdl_locked = 1'b0;
    logic        prev_hold  = 1'b0;
    logic [31:0] prev_di    = 32'h0;
    logic [1:0]  m_vld, m_rdy, m_exp;
    logic        m_w;
    logic [7:0]  m_b;
    logic [31:0] m_d;

    always #5 clk = ~clk;

    simpleuart_tx_arbiter dut (
        .clk          (clk),
        .resetn       (resetn),
        .req0_valid   (req0_valid),
        .req0_data    (req0_data),
        .req0_last    (req0_last),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_data    (req1_data),
        .req1_last    (req1_last),
        .req1_ready   (req1_ready),
        .div_cfg_valid(div_cfg_valid),
        .div_cfg_data (div_cfg_data),
        .div_cfg_ready(div_cfg_ready),
        .reg_div_we   (reg_div_we),
        .reg_div_di   (reg_div_di),
        .reg_dat_we   (reg_dat_we),
        .reg_dat_di   (reg_dat_di),
        .reg_dat_wait (reg_dat_wait),
        .busy         (busy),
        .grant_id     (grant_id),
        .locked       (locked)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: sample handshakes at negedge, drop accepted valids after the edge.
    task automatic tick();
        @(negedge clk);
        acc0 = req0_valid && req0_ready;
        acc1 = req1_valid && req1_ready;
        accc = div_cfg_valid && div_cfg_ready;
        @(posedge clk);
        #1;
        if (acc0) req0_valid = 1'b0;
        if (acc1) req1_valid = 1'b0;
        if (accc) div_cfg_valid = 1'b0;
    endtask

    task automatic offer(input logic s, input logic [7:0] b, input logic l);
        if (!s) begin
            req0_valid = 1'b1; req0_data = b; req0_last = l; exp_q0.push_back(b);
        end else begin
            req1_valid = 1'b1; req1_data = b; req1_last = l; exp_q1.push_back(b);
        end
    endtask

    task automatic offer_cfg(input logic [31:0] v);
        div_cfg_valid = 1'b1;
        div_cfg_data  = v;
        exp_div.push_back(v);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        reg_dat_wait = 1'b0;
        while ((req0_valid || req1_valid || div_cfg_valid || busy ||
                (exp_q0.size() + exp_q1.size() + exp_div.size()) != 0) && n < 200) begin
            tick();
            n++;
        end
        chk({name, "_left"}, 32'(exp_q0.size() + exp_q1.size() + exp_div.size()), 32'd0);
        chk({name, "_timeout"}, 32'(n < 200), 32'd1);
    endtask

    // Called just after a rising edge; runs reset and the default divider write.
    task automatic do_reset();
        resetn        = 1'b0;
        req0_valid    = 1'b0;
        req1_valid    = 1'b0;
        div_cfg_valid = 1'b0;
        reg_dat_wait  = 1'b0;
        req0_last     = 1'b1;
        req1_last     = 1'b1;
        exp_q0.delete();
        exp_q1.delete();
        exp_div.delete();
        repeat (3) @(posedge clk);
        #1;
        exp_div.push_back(32'd104);
        resetn = 1'b1;
        tick();
        chk("init_div_we", 32'(reg_div_we), 32'hF);
        chk("init_div_di", reg_div_di, 32'd104);
        tick();
        chk("init_done_div_we", 32'(reg_div_we), 32'd0);
        chk("init_done_busy", 32'(busy), 32'd0);
        chk("init_done_dat_we", 32'(reg_dat_we), 32'd0);
    endtask

    // Monitor: scoreboard pops and request-level arbitration model.
    always @(negedge clk) begin
        if (!resetn) begin
            mdl_last   = 1'b1;
            mdl_owner  = 1'b0;
            mdl_locked = 1'b0;
            prev_hold  = 1'b0;
        end else begin
            chk("locked", 32'(locked), 32'(mdl_locked));
            if (prev_hold) begin
                chk("issue_hold_we", 32'(reg_dat_we), 32'd1);
                chk("issue_hold_di", reg_dat_di, prev_di);
            end
            prev_hold = reg_dat_we && reg_dat_wait;
            prev_di   = reg_dat_di;

            if (reg_dat_we && !reg_dat_wait) begin
                wr_log.push_back(reg_dat_di[7:0]);
                gr_log.push_back(grant_id);
                chk("write_src", 32'(grant_id), 32'(mdl_last));
                if ((grant_id && exp_q1.size() == 0) || (!grant_id && exp_q0.size() == 0)) begin
                    total++;
                    bad++;
                    $display("FAIL write_unexpected: got data 0x%0h from %0d, expected no write", reg_dat_di, grant_id);
                end else begin
                    if (grant_id) m_b = exp_q1.pop_front();
                    else          m_b = exp_q0.pop_front();
                    chk("write_data", reg_dat_di, {24'h0, m_b});
                end
            end

            if (reg_div_we != 4'h0) begin
                chk("div_we_value", 32'(reg_div_we), 32'hF);
                if (exp_div.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL div_unexpected: got div write 0x%0h, expected none", reg_div_di);
                end else begin
                    m_d = exp_div.pop_front();
                    chk("div_data", reg_div_di, m_d);
                end
            end

            m_vld = {req1_valid, req0_valid};
            m_rdy = {req1_ready, req0_ready};
            if (busy) begin
                chk("ready_while_busy", 32'({div_cfg_ready, m_rdy}), 32'd0);
            end else if (div_cfg_ready || m_rdy != 2'b00) begin
                if (div_cfg_valid && !mdl_locked) begin
                    chk("cfg_priority", 32'({div_cfg_ready, m_rdy}), 32'b100);
                end else begin
                    if (mdl_locked) m_w = mdl_owner;
                    else if (m_vld == 2'b11) m_w = ~mdl_last;
                    else m_w = req1_valid;
                    m_exp = m_vld[m_w] ? (m_w ? 2'b10 : 2'b01) : 2'b00;
                    chk("ready_select", 32'({div_cfg_ready, m_rdy}), 32'({1'b0, m_exp}));
                    if (m_exp != 2'b00) begin
                        mdl_last  = m_w;
                        mdl_owner = m_w;
`ifdef UART_ARB_PKT_LOCK_EN
                        mdl_locked = !(m_w ? req1_last : req0_last);
`endif
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        resetn        = 1'b0;
        req0_valid    = 1'b0; req0_data = 8'h0; req0_last = 1'b1;
        req1_valid    = 1'b0; req1_data = 8'h0; req1_last = 1'b1;
        div_cfg_valid = 1'b0; div_cfg_data = 32'h0;
        reg_dat_wait  = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_req0_ready", 32'(req0_ready), 32'd0);
        chk("rst_req1_ready", 32'(req1_ready), 32'd0);
        chk("rst_cfg_ready", 32'(div_cfg_ready), 32'd0);
        chk("rst_div_we", 32'(reg_div_we), 32'd0);
        chk("rst_div_di", reg_div_di, 32'd0);
        chk("rst_dat_we", 32'(reg_dat_we), 32'd0);
        chk("rst_dat_di", reg_dat_di, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        do_reset();

        // Both requesters saturated: strict alternation at one byte per two cycles.
        wr_log.delete();
        gr_log.delete();
        offer(1'b0, 8'hAA, 1'b1);
        offer(1'b1, 8'h55, 1'b1);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (acc0) offer(1'b0, 8'hAA, 1'b1);
            if (acc1) offer(1'b1, 8'h55, 1'b1);
        end
        chk("rr_rate", 32'(wr_log.size()), 32'd10);
        drain("rr_drain");
        for (int i = 0; i < 4; i++) begin
            chk("rr_order", 32'(wr_log[i]), (i % 2 == 0) ? 32'hAA : 32'h55);
            chk("rr_grant", 32'(gr_log[i]), 32'(i % 2));
        end

        // Back-pressure: write held while the UART is busy.
        offer(1'b0, 8'h41, 1'b1);
        reg_dat_wait = 1'b1;
        tick();
        chk("hold_accept_we", 32'(reg_dat_we), 32'd1);
        repeat (5) tick();
        chk("hold_we", 32'(reg_dat_we), 32'd1);
        chk("hold_di", reg_dat_di, 32'h41);
        reg_dat_wait = 1'b0;
        tick();
        chk("hold_release_we", 32'(reg_dat_we), 32'd0);
        chk("hold_release_busy", 32'(busy), 32'd0);
        drain("hold_drain");

`ifdef UART_ARB_PKT_LOCK_EN
        // Packet lock: req0's three-byte packet goes out before any req1 byte.
        offer(1'b0, 8'hC0, 1'b0);
        tick();
        chk("lock_set", 32'(locked), 32'd1);
        offer(1'b0, 8'hC1, 1'b0);
        offer(1'b1, 8'h77, 1'b1);
        sent = 2;
        for (int i = 0; i < 60 && req0_valid; i++) begin
            tick();
            chk("lock_owner_only", 32'(acc1), 32'd0);
            if (acc0 && sent < 3) begin
                offer(1'b0, 8'hC2, 1'b1);
                sent = 3;
            end
        end
        chk("lock_clear", 32'(locked), 32'd0);
        drain("lock_drain");
`else
        sent = 0;
`endif

        // Divider update and data request together: update goes first.
        offer_cfg(32'd868);
        offer(1'b0, 8'h3C, 1'b1);
        tick();
        chk("cfg_first_taken", 32'(accc), 32'd1);
        chk("cfg_first_data_blocked", 32'(acc0), 32'd0);
        chk("cfg_we", 32'(reg_div_we), 32'hF);
        chk("cfg_di", reg_div_di, 32'd868);
        tick();
        chk("cfg_one_cycle", 32'(reg_div_we), 32'd0);
        tick();
        chk("cfg_then_data", 32'(acc0), 32'd1);
        drain("cfg_drain");

        // Randomized traffic with random back-pressure and divider updates.
        for (int i = 0; i < 800; i++) begin
            tick();
            if (!req0_valid && $urandom_range(2) == 0) offer(1'b0, 8'($urandom), 1'b1);
            if (!req1_valid && $urandom_range(2) == 0) offer(1'b1, 8'($urandom), 1'b1);
            if (!div_cfg_valid && $urandom_range(19) == 0) offer_cfg($urandom);
            reg_dat_wait = ($urandom_range(2) == 0);
        end
        drain("rand_drain");

        // Reset during ISSUE drops the byte and reruns the default divider write.
        offer(1'b0, 8'h99, 1'b1);
        reg_dat_wait = 1'b1;
        tick();
        chk("midrst_issue_we", 32'(reg_dat_we), 32'd1);
        resetn = 1'b0;
        #1;
        chk("midrst_dat_we", 32'(reg_dat_we), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_div_we", 32'(reg_div_we), 32'd0);
        do_reset();
        drain("final_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
